// File: rtl/fetch_queue.sv
// Instruction-byte prefetch queue: fetches sequential bytes, exposes the head three bytes and PC.
// Optional FETCH_BYPASS_EN: an ack into an empty queue is visible combinationally that cycle.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    output logic                    mem_req,
    output logic [15:0]             mem_addr,
    input  logic                    mem_ack,
    input  logic [7:0]              mem_rdata,
    output logic [$clog2(DEPTH):0]  q_count,
    output logic [23:0]             q_data,
    output logic [15:0]             q_pc,
    input  logic [1:0]              pop_n,
    input  logic                    redirect,
    input  logic [15:0]             redirect_pc,
    output logic                    pop_err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    r_buf [DEPTH];
    logic [AW-1:0] r_rd_ptr, r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [15:0]   r_fetch_pc, r_head_pc, r_req_addr;
    logic          r_req, r_discard, r_pop_err;

    logic          w_ack, w_accept, w_bypass, w_bypass_pop, w_write, w_pop_ok;
    logic [1:0]    w_popped, w_rd_adv;
    logic [CW-1:0] w_q_count, w_count_d;
    logic [15:0]   w_fetch_pc_d;
    logic [7:0]    w_peek0, w_peek1, w_peek2;

    always_comb begin
        w_ack    = r_req & mem_ack;
        w_accept = w_ack & ~r_discard & ~redirect;
        w_peek0  = r_buf[r_rd_ptr];
        w_peek1  = r_buf[r_rd_ptr + AW'(1)];
        w_peek2  = r_buf[r_rd_ptr + AW'(2)];
`ifdef FETCH_BYPASS_EN
        w_bypass  = w_accept & (r_count == '0);
        w_q_count = w_bypass ? CW'(1) : r_count;
        q_data    = w_bypass ? {w_peek2, w_peek1, mem_rdata} : {w_peek2, w_peek1, w_peek0};
        q_pc      = w_bypass ? r_req_addr : r_head_pc;
`else
        w_bypass  = 1'b0;
        w_q_count = r_count;
        q_data    = {w_peek2, w_peek1, w_peek0};
        q_pc      = r_head_pc;
`endif
        q_count  = w_q_count;
        w_pop_ok = CW'(pop_n) <= w_q_count;
        w_popped = (redirect || !w_pop_ok) ? 2'd0 : pop_n;
        // A byte consumed straight from the bus never occupies a buffer slot.
        w_bypass_pop = w_bypass & (w_popped == 2'd1);
        w_write      = w_accept & ~w_bypass_pop;
        w_rd_adv     = w_bypass_pop ? 2'd0 : w_popped;
        if (redirect) begin
            w_count_d    = '0;
            w_fetch_pc_d = redirect_pc;
        end else begin
            w_count_d    = r_count + CW'(w_write) - CW'(w_rd_adv);
            w_fetch_pc_d = w_accept ? r_fetch_pc + 16'd1 : r_fetch_pc;
        end
    end

    assign mem_req  = r_req;
    assign mem_addr = r_req_addr;
    assign pop_err  = r_pop_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) r_buf[i] <= 8'h00;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_fetch_pc <= RESET_PC;
            r_head_pc  <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_req      <= 1'b0;
            r_discard  <= 1'b0;
            r_pop_err  <= 1'b0;
        end else begin
            if (w_write) r_buf[r_wr_ptr] <= mem_rdata;
            r_wr_ptr   <= r_wr_ptr + AW'(w_write);
            r_rd_ptr   <= redirect ? r_wr_ptr : r_rd_ptr + AW'(w_rd_adv);
            r_head_pc  <= redirect ? redirect_pc : r_head_pc + 16'(w_popped);
            r_count    <= w_count_d;
            r_fetch_pc <= w_fetch_pc_d;
            r_pop_err  <= r_pop_err | (~redirect & ~w_pop_ok);
            // An outstanding request is never withdrawn; a redirect just marks its data stale.
            if (redirect && r_req && !w_ack) r_discard <= 1'b1;
            else if (w_ack)                  r_discard <= 1'b0;
            if (!r_req || w_ack) begin
                r_req      <= w_count_d < CW'(DEPTH);
                r_req_addr <= w_fetch_pc_d;
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: expected fetch addresses are queued as scoreboard entries
// and checked as each request is acknowledged; queue state is checked after each step.
module tb_fetch_queue;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [2:0]  q_count;
    logic [23:0] q_data;
    logic [15:0] q_pc;
    logic [1:0]  pop_n;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        pop_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_addr[$];

    fetch_queue #(.DEPTH(4), .RESET_PC(16'h0400)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .q_count(q_count), .q_data(q_data), .q_pc(q_pc),
        .pop_n(pop_n), .redirect(redirect), .redirect_pc(redirect_pc), .pop_err(pop_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: optionally ack a pending request (data = addr[7:0]), then advance.
    task automatic tick(input bit ack);
        mem_ack   = ack & mem_req;
        mem_rdata = mem_addr[7:0];
        if (mem_ack) begin
            n_checks++;
            assert (exp_addr.size() != 0) else begin
                n_errors++;
                $error("FAIL sb_underflow: got request %h expected none", mem_addr);
            end
            if (exp_addr.size() != 0) chk("sb_addr", mem_addr, exp_addr.pop_front());
        end
        @(posedge i_clk);
        #1;
        mem_ack  = 1'b0;
        pop_n    = 2'd0;
        redirect = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; mem_ack = 1'b0; mem_rdata = 8'h00;
        pop_n = 2'd0; redirect = 1'b0; redirect_pc = 16'h0000;
        @(posedge i_clk); @(posedge i_clk); #1;
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 16'h0400);
        chk("rst_count", q_count, 0);
        chk("rst_data", q_data, 0);
        chk("rst_pc", q_pc, 16'h0400);
        chk("rst_err", pop_err, 0);

        // Fill from reset with single-cycle acks.
        i_rst = 1'b0;
        for (int a = 0; a < 4; a++) exp_addr.push_back(16'h0400 + 16'(a));
        chk("rel_req0", mem_req, 0);
        tick(1);
        chk("first_req", mem_req, 1);
        chk("first_addr", mem_addr, 16'h0400);
        for (int k = 0; k < 4; k++) tick(1);
        chk("full_count", q_count, 4);
        chk("full_data", q_data, 24'h020100);
        chk("full_pc", q_pc, 16'h0400);
        chk("full_req", mem_req, 0);
        tick(1);
        chk("full_hold_req", mem_req, 0);
        chk("full_hold_count", q_count, 4);

        // Pop three from a full queue.
        pop_n = 2'd3;
        tick(1);
        chk("pop3_count", q_count, 1);
        chk("pop3_pc", q_pc, 16'h0403);
        chk("pop3_byte", q_data[7:0], 8'h03);
        chk("pop3_req", mem_req, 1);
        chk("pop3_addr", mem_addr, 16'h0404);

        // Redirect while request 0406 is pending; its ack arrives three cycles later.
        exp_addr.push_back(16'h0404); exp_addr.push_back(16'h0405);
        tick(1); tick(1);
        chk("pre_redir_addr", mem_addr, 16'h0406);
        redirect = 1'b1; redirect_pc = 16'hC000;
        tick(0);
        chk("redir_count", q_count, 0);
        chk("redir_pc", q_pc, 16'hC000);
        chk("discard_req", mem_req, 1);
        chk("discard_addr", mem_addr, 16'h0406);
        tick(0); tick(0);
        exp_addr.push_back(16'h0406);
        tick(1);
        chk("dropped_count", q_count, 0);
        chk("new_req", mem_req, 1);
        chk("new_addr", mem_addr, 16'hC000);
        exp_addr.push_back(16'hC000);
        tick(1);
        chk("new_count", q_count, 1);
        chk("new_byte", q_data[7:0], 8'h00);
        chk("new_pc", q_pc, 16'hC000);

        // Redirect, ack and over-pop in the same cycle.
        exp_addr.push_back(16'hC001);
        redirect = 1'b1; redirect_pc = 16'h1234; pop_n = 2'd2;
        tick(1);
        chk("rdack_count", q_count, 0);
        chk("rdack_err", pop_err, 0);
        chk("rdack_addr", mem_addr, 16'h1234);
        exp_addr.push_back(16'h1234);
        tick(1);
        chk("rdack_byte", q_data[7:0], 8'h34);
        chk("rdack_pc", q_pc, 16'h1234);

        // Over-pop: nothing removed, error sticks.
        exp_addr.push_back(16'h1235);
        tick(1);
        chk("two_count", q_count, 2);
        pop_n = 2'd3;
        tick(0);
        chk("bad_count", q_count, 2);
        chk("bad_pc", q_pc, 16'h1234);
        chk("bad_err", pop_err, 1);
        pop_n = 2'd1;
        tick(0);
        chk("after_count", q_count, 1);
        chk("after_pc", q_pc, 16'h1235);
        chk("sticky_err", pop_err, 1);

        // PC wrap across 16'hFFFF.
        exp_addr.push_back(16'h1236);
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick(1);
        chk("wrap_req_addr", mem_addr, 16'hFFFE);
        chk("wrap_err", pop_err, 1);
        exp_addr.push_back(16'hFFFE); exp_addr.push_back(16'hFFFF);
        exp_addr.push_back(16'h0000);
        tick(1); tick(1); tick(1);
        chk("wrap_count", q_count, 3);
        chk("wrap_data", q_data, 24'h00FFFE);
        chk("wrap_next_addr", mem_addr, 16'h0001);
        pop_n = 2'd2;
        tick(0);
        chk("wrap_pc", q_pc, 16'h0000);
        chk("wrap_byte", q_data[7:0], 8'h00);

        // Reset with a request outstanding; a late ack must be ignored.
        i_rst = 1'b1;
        tick(0);
        chk("rst2_req", mem_req, 0);
        chk("rst2_err", pop_err, 0);
        chk("rst2_count", q_count, 0);
        chk("rst2_pc", q_pc, 16'h0400);
        i_rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 8'hAA;
        @(posedge i_clk); #1;
        mem_ack = 1'b0;
        chk("late_ack_count", q_count, 0);
        chk("late_ack_req", mem_req, 1);
        chk("late_ack_addr", mem_addr, 16'h0400);
`ifdef FETCH_BYPASS_EN
        mem_ack = 1'b1; mem_rdata = 8'h5A;
        #1;
        chk("bypass_count", q_count, 1);
        chk("bypass_byte", q_data[7:0], 8'h5A);
        chk("bypass_pc", q_pc, 16'h0400);
        @(posedge i_clk); #1;
        mem_ack = 1'b0;
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
